wb_ext_mem_arbiter: RTL and testbench

- Round-robin Wishbone B4 arbiter that shares the single external-memory slave port among NUM_MASTERS masters. The default masters are the CPU memory port (index 0) and the debug memory-access module (index 1).
- Sits between the intercon master-side signals and the wb_ext_* top-level pins.
- Holds the grant for a master's whole cycle, including incrementing bursts.
- Provides a per-grant watchdog that terminates hung cycles with err.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_ext_mem_arbiter_rr_pick.sv | 35 +++
 rtl/wb_ext_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_ext_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the external-memory Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERR   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // OR-accumulates set bit positions; exact only for one-hot or zero input.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_ext_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_last.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [N-1:0] w_rot;
    logic         w_found;
    int unsigned  w_pos;

    always_comb begin
        // Doubling then shifting puts master (last+1) at bit 0 without a wrap case.
        w_rot   = N'({i_req, i_req} >> (32'(i_last) + 32'd1));
        w_found = 1'b0;
        w_pos   = 0;
        o_idx   = '0;
        o_grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_pos   = (32'(i_last) + 32'd1 + i) % N;
            end
        end
        if (w_found) begin
            o_idx   = IW'(w_pos);
            o_grant = N'(1) << w_pos;
        end
    end

endmodule

// File: rtl/wb_ext_mem_arbiter.sv
// Round-robin Wishbone B4 arbiter sharing the external-memory slave port,
// with cycle-long grant hold and a per-grant watchdog.
module wb_ext_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 27,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0][AW-1:0]      m_adr_i,
    input  logic [NUM_MASTERS-1:0][DW-1:0]      m_dat_i,
    input  logic [NUM_MASTERS-1:0][DW/8-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS-1:0]              m_cyc_i,
    input  logic [NUM_MASTERS-1:0]              m_stb_i,
    input  logic [NUM_MASTERS-1:0][2:0]         m_cti_i,
    input  logic [NUM_MASTERS-1:0][1:0]         m_bte_i,
    output logic [DW-1:0]                       m_dat_o,
    output logic [NUM_MASTERS-1:0]              m_ack_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic [NUM_MASTERS-1:0]              m_rty_o,
    output logic [AW-1:0]                       s_adr_o,
    output logic [DW-1:0]                       s_dat_o,
    output logic [DW/8-1:0]                     s_sel_o,
    output logic                                s_we_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic [2:0]                          s_cti_o,
    output logic [1:0]                          s_bte_o,
    input  logic [DW-1:0]                       s_dat_i,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    input  logic                                s_rty_i,
    output logic [NUM_MASTERS-1:0]              grant_o,
    output logic                                timeout_o
);

    localparam int              IW      = $clog2(NUM_MASTERS);
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t             r_state, w_next;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]          r_last, w_last_nxt;
    logic [CNT_W-1:0]       r_wd, w_wd_nxt;

    logic [NUM_MASTERS-1:0] w_pick_grant;
    logic [IW-1:0]          w_pick_idx;
    logic [IW-1:0]          w_own;
    logic                   w_busy;
    logic                   w_resp;

    rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .i_req   (m_cyc_i),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_own     = IW'(onehot2idx(8'(r_grant)));
    assign w_busy    = (r_state == BUSY);
    assign w_resp    = s_ack_i | s_err_i | s_rty_i;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = r_grant;
    assign timeout_o = (r_state == ERR);

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (w_busy) begin
            s_adr_o = m_adr_i[w_own];
            s_dat_o = m_dat_i[w_own];
            s_sel_o = m_sel_i[w_own];
            s_we_o  = m_we_i[w_own];
            s_cyc_o = m_cyc_i[w_own];
            s_stb_o = m_stb_i[w_own];
            s_cti_o = m_cti_i[w_own];
            s_bte_o = m_bte_i[w_own];
        end
    end

    // Responses reach only the owner, and only while the slave path is live.
    assign m_ack_o = r_grant & {NUM_MASTERS{w_busy & s_ack_i}};
    assign m_rty_o = r_grant & {NUM_MASTERS{w_busy & s_rty_i}};
    assign m_err_o = r_grant & {NUM_MASTERS{(w_busy & s_err_i) | (r_state == ERR)}};

    always_comb begin
        w_next      = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_wd_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (|m_cyc_i) begin
                    w_next      = BUSY;
                    w_grant_nxt = w_pick_grant;
                    w_last_nxt  = w_pick_idx;
                end
            end
            BUSY: begin
                if (!m_cyc_i[w_own]) begin
                    w_next      = IDLE;
                    w_grant_nxt = '0;
                end else if (WD_EN && s_stb_o && !w_resp) begin
                    if (r_wd == WD_LAST) w_next = ERR;
                    else                 w_wd_nxt = r_wd + 1'b1;
                end
            end
            ERR: w_next = DRAIN;
            DRAIN: begin
                if (!m_cyc_i[w_own]) begin
                    w_next      = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_next      = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_wd    <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

endmodule

// File: tb/tb_wb_ext_mem_arbiter.sv
// Directed/randomized bench for wb_ext_mem_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_wb_ext_mem_arbiter;
    import wb_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 27;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic [N-1:0][AW-1:0] m_adr;
    logic [N-1:0][DW-1:0] m_dat;
    logic [N-1:0][SW-1:0] m_sel;
    logic [N-1:0]         m_we, m_cyc, m_stb;
    logic [N-1:0][2:0]    m_cti;
    logic [N-1:0][1:0]    m_bte;
    logic [DW-1:0]        m_dat_o;
    logic [N-1:0]         m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [SW-1:0]        s_sel_o;
    logic                 s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]           s_cti_o;
    logic [1:0]           s_bte_o;
    logic [DW-1:0]        s_dat_i;
    logic                 s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]         grant_o;
    logic                 timeout_o;

    wb_ext_mem_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Master bus-functional state
    bit             mact   [N];
    bit             mpend  [N];
    bit             mburst [N];
    bit             mstub  [N];
    bit             mwe    [N];
    int             mbeats [N];
    int             mlen   [N];
    int             mleft  [N];
    logic [AW-1:0]  madr   [N];
    logic [DW-1:0]  mdata  [N];
    logic [SW-1:0]  msel   [N];

    // Slave responder: 0 random-latency ack, 1 silent, 2 err, 3 rty
    int slv_mode  = 0;
    int slv_wait  = 0;
    bit slv_fixed = 1'b0;
    bit slv_late  = 1'b0;

    // Reference model: owner (-1 = none), rotation pointer, unanswered age
    int mo, mlast, mage;
    bit merr, mdrain;

    bit           e_act;
    logic [N-1:0] e_grant, e_ack, e_err, e_rty;

    int tcount = 0, stb_tick = -1, to_tick = -1, n_to = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mo = -1; mlast = N - 1; mage = 0; merr = 1'b0; mdrain = 1'b0;
    endtask

    task automatic launch(input int i);
        mact[i]   = 1'b1;
        mbeats[i] = mlen[i];
        madr[i]   = AW'($urandom) & ~AW'(3);
        mdata[i]  = DW'($urandom);
        msel[i]   = SW'($urandom_range(1, (1 << SW) - 1));
    endtask

    task automatic start_txn(input int i, input logic [AW-1:0] adr, input int len,
                             input bit burst, input bit we, input int extra);
        mlen[i] = len; mburst[i] = burst; mwe[i] = we; mleft[i] = extra;
        launch(i);
        madr[i] = adr;
    endtask

    task automatic finish_txn(input int i);
        mact[i] = 1'b0;
        if (mleft[i] > 0) begin
            mleft[i]--;
            mpend[i] = 1'b1;
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = mact[i];
            m_stb[i] = mact[i];
            m_adr[i] = mact[i] ? madr[i] : AW'($urandom);
            m_dat[i] = mdata[i];
            m_sel[i] = msel[i];
            m_we[i]  = mwe[i];
            m_cti[i] = !mburst[i] ? CTI_CLASSIC : ((mbeats[i] == 1) ? CTI_EOB : CTI_INCR);
            m_bte[i] = 2'b00;
        end
    endtask

    task automatic predict_and_respond();
        e_act   = (mo >= 0) && !merr && !mdrain;
        e_grant = (mo >= 0) ? (N'(1) << mo) : '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        s_dat_i = slv_fixed ? 32'hDEADBEEF : DW'($urandom);
        if (e_act && m_stb[mo]) begin
            case (slv_mode)
                0: if (slv_wait == 0) begin
                       s_ack_i  = 1'b1;
                       slv_wait = $urandom_range(0, 2);
                   end else slv_wait--;
                2: s_err_i = 1'b1;
                3: s_rty_i = 1'b1;
                default: ;
            endcase
        end
        if (slv_late) s_ack_i = 1'b1;
        e_ack = (e_act && s_ack_i) ? e_grant : '0;
        e_rty = (e_act && s_rty_i) ? e_grant : '0;
        e_err = ((e_act && s_err_i) || merr) ? e_grant : '0;
    endtask

    task automatic check_outputs();
        logic [AW-1:0] x_adr; logic [DW-1:0] x_dat; logic [SW-1:0] x_sel;
        logic x_we, x_cyc, x_stb; logic [2:0] x_cti;
        x_adr = '0; x_dat = '0; x_sel = '0; x_we = 1'b0; x_cyc = 1'b0; x_stb = 1'b0; x_cti = '0;
        if (e_act) begin
            x_adr = m_adr[mo]; x_dat = m_dat[mo]; x_sel = m_sel[mo]; x_we = m_we[mo];
            x_cyc = m_cyc[mo]; x_stb = m_stb[mo]; x_cti = m_cti[mo];
        end
        chk("grant",   64'(grant_o),   64'(e_grant));
        chk("s_cyc",   64'(s_cyc_o),   64'(x_cyc));
        chk("s_stb",   64'(s_stb_o),   64'(x_stb));
        chk("s_adr",   64'(s_adr_o),   64'(x_adr));
        chk("s_dat",   64'(s_dat_o),   64'(x_dat));
        chk("s_sel",   64'(s_sel_o),   64'(x_sel));
        chk("s_we",    64'(s_we_o),    64'(x_we));
        chk("s_cti",   64'(s_cti_o),   64'(x_cti));
        chk("m_ack",   64'(m_ack_o),   64'(e_ack));
        chk("m_err",   64'(m_err_o),   64'(e_err));
        chk("m_rty",   64'(m_rty_o),   64'(e_rty));
        chk("timeout", 64'(timeout_o), 64'(merr));
        chk("m_dat",   64'(m_dat_o),   64'(s_dat_i));
        if (timeout_o) begin n_to++; to_tick = tcount; end
        if (e_act && m_stb[mo] && stb_tick < 0) stb_tick = tcount;
    endtask

    task automatic model_step();
        bit found;
        if (mo < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && m_cyc[(mlast + k) % N]) begin
                    found = 1'b1;
                    mo    = (mlast + k) % N;
                    mlast = mo;
                    mage  = 0;
                end
            end
        end else if (merr) begin
            merr = 1'b0; mdrain = 1'b1;
        end else if (mdrain) begin
            if (!m_cyc[mo]) begin mo = -1; mdrain = 1'b0; end
        end else if (!m_cyc[mo]) begin
            mo = -1; mage = 0;
        end else if (m_stb[mo] && !(s_ack_i || s_err_i || s_rty_i)) begin
            if (mage == TO - 1) begin merr = 1'b1; mage = 0; end
            else mage++;
        end else mage = 0;
    endtask

    task automatic masters_step();
        for (int i = 0; i < N; i++) begin
            if (mpend[i]) begin
                mpend[i] = 1'b0;
                launch(i);
            end else if (mact[i]) begin
                if (e_ack[i]) begin
                    mbeats[i]--;
                    madr[i]  = madr[i] + AW'(4);
                    mdata[i] = DW'($urandom);
                    if (mbeats[i] == 0) finish_txn(i);
                end else if ((e_err[i] || e_rty[i]) && !mstub[i]) begin
                    finish_txn(i);
                end
            end
        end
    endtask

    task automatic tick();
        drive_masters();
        predict_and_respond();
        #1;
        check_outputs();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        masters_step();
        tcount++;
        @(negedge clk);
    endtask

    function automatic bit busy();
        bit b;
        b = (mo >= 0);
        for (int i = 0; i < N; i++) b = b | mact[i] | mpend[i];
        return b;
    endfunction

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin tick(); n++; end
        chk("idle_budget", 64'(busy()), 64'(0));
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            mact[i] = 1'b0; mpend[i] = 1'b0; mstub[i] = 1'b0; mleft[i] = 0;
            mbeats[i] = 0; mburst[i] = 1'b0; mwe[i] = 1'b0;
            mdata[i] = '0; msel[i] = '0; madr[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clear_masters();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        clear_masters();
        do_reset();

        // Single classic read, slave answers after two wait cycles
        slv_fixed = 1'b1; slv_wait = 2;
        start_txn(0, 27'h100, 1, 1'b0, 1'b0, 0);
        run_idle(20);
        slv_fixed = 1'b0;

        // Contention from reset: m0 has two bursts queued, m1 one
        do_reset();
        start_txn(0, AW'($urandom) & ~AW'(3), 4, 1'b1, 1'b1, 1);
        start_txn(1, AW'($urandom) & ~AW'(3), 4, 1'b1, 1'b0, 0);
        run_idle(200);

        // Burst lock: m0 requests while m1's 8-beat burst is in progress
        start_txn(1, AW'($urandom) & ~AW'(3), 8, 1'b1, 1'b0, 0);
        n = 0;
        while (mbeats[1] > 6 && n < 60) begin tick(); n++; end
        chk("burst_beat2", 64'(mbeats[1] > 6), 64'(0));
        start_txn(0, AW'($urandom) & ~AW'(3), 1, 1'b0, 1'b1, 0);
        run_idle(200);

        // Watchdog with a silent slave; late ack during drain must be dropped
        slv_mode = 1; mstub[0] = 1'b1; stb_tick = -1; to_tick = -1; n_to = 0;
        start_txn(0, AW'($urandom) & ~AW'(3), 1, 1'b0, 1'b0, 0);
        repeat (21) tick();
        chk("wd_pulses", 64'(n_to), 64'(1));
        chk("wd_delay", 64'(to_tick - stb_tick), 64'(TO));
        slv_late = 1'b1; tick(); slv_late = 1'b0;
        mact[0] = 1'b0; mstub[0] = 1'b0; slv_mode = 0;
        run_idle(20);

        // Error then retry returned to master 1
        slv_mode = 2;
        start_txn(1, AW'($urandom) & ~AW'(3), 1, 1'b0, 1'b1, 0);
        run_idle(20);
        slv_mode = 3;
        start_txn(1, AW'($urandom) & ~AW'(3), 1, 1'b0, 1'b0, 0);
        run_idle(20);
        slv_mode = 0;

        // Asynchronous reset during beat 3 of a burst
        start_txn(0, AW'($urandom) & ~AW'(3), 8, 1'b1, 1'b0, 0);
        n = 0;
        while (mbeats[0] > 6 && n < 60) begin tick(); n++; end
        chk("rst_beat3", 64'(mbeats[0] > 6), 64'(0));
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_m_ack", 64'(m_ack_o), 64'(0));
        @(negedge clk);
        clear_masters();
        repeat (2) tick();
        rst_n = 1'b1;
        start_txn(1, AW'($urandom) & ~AW'(3), 2, 1'b1, 1'b1, 0);
        start_txn(0, AW'($urandom) & ~AW'(3), 2, 1'b1, 1'b0, 0);
        tick();
        tick();
        chk("post_rst_first", 64'(grant_o), 64'(2'b01));
        run_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
